// File: rtl/memory_arbiter_if.sv
// Bundles the fetch, data and RAM sides of the shared memory port.
// The arbiter takes the slave view; the request unit and RAM model take the master view.
interface memory_arbiter_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              merr;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Data wins arbitration; a streak counter forces a fetch after MAX_DSTREAK data grants.
//  state | meaning
//  IDLE  | no grant, arbitrate this cycle
//  DSERV | data port owns the RAM until ACCESS/ERROR or withdrawal
//  ISERV | fetch port owns the RAM until ACCESS/ERROR or withdrawal
module memory_arbiter #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    memory_arbiter_if.slave   bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = '0;
    localparam logic [WORD_W-1:0] WORD_ZERO  = '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DSERV = 2'd1;
    localparam logic [1:0] ST_ISERV = 2'd2;

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d, dstreak_inc;
    logic          merr_q, merr_d;
    logic          dreq;

    assign dreq     = bus.dREN | bus.dWEN;
    assign bus.merr = merr_q;

    // Streak only grows while a fetch is actually being held off, and saturates.
    assign dstreak_inc = !bus.iREN                 ? '0 :
                         (dstreak_q == STREAK_MAX) ? dstreak_q :
                                                     dstreak_q + SW'(1);

    always_comb begin
        state_d      = state_q;
        dstreak_d    = dstreak_q;
        merr_d       = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = ADDR_ZERO;
        bus.ramstore = WORD_ZERO;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = WORD_ZERO;
        bus.dload    = WORD_ZERO;
        case (state_q)
            ST_IDLE: begin
                if (dreq && (!bus.iREN || dstreak_q < STREAK_MAX)) begin
                    state_d = ST_DSERV;
                end else if (bus.iREN) begin
                    state_d = ST_ISERV;
                end else begin
                    dstreak_d = '0;
                end
            end
            ST_DSERV: begin
                bus.ramaddr = bus.daddr;
                bus.ramWEN  = bus.dWEN;
                bus.ramREN  = bus.dREN & ~bus.dWEN;
                if (bus.dWEN) begin
                    bus.ramstore = bus.dstore;
                end
                if (!dreq) begin
                    state_d = ST_IDLE;
                end else if (bus.ramstate == RS_ACCESS) begin
                    bus.dwait = 1'b0;
                    if (!bus.dWEN) begin
                        bus.dload = bus.ramload;
                    end
                    dstreak_d = dstreak_inc;
                    state_d   = ST_IDLE;
                end else if (bus.ramstate == RS_ERROR) begin
                    bus.dwait = 1'b0;
                    merr_d    = 1'b1;
                    dstreak_d = dstreak_inc;
                    state_d   = ST_IDLE;
                end
            end
            ST_ISERV: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    state_d = ST_IDLE;
                end else if (bus.ramstate == RS_ACCESS) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                    dstreak_d = '0;
                    state_d   = ST_IDLE;
                end else if (bus.ramstate == RS_ERROR) begin
                    bus.iwait = 1'b0;
                    merr_d    = 1'b1;
                    dstreak_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            dstreak_q <= '0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            merr_q    <= merr_d;
        end
    end
endmodule
